mips_multicycle_core: RTL and testbench

Multicycle successor to the single-cycle MIPS top. It runs the same integer subset through a Moore control FSM and a shared datapath. The ALU is reused for PC increment and branch target. There is one unified instruction/data memory port with a req/ready handshake, so variable-latency memories (wait states) are supported. A selectable register is mirrored on Test_Value for board/bench observation, and illegal opcodes halt the core.

---
 rtl/mips_multicycle_core.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS integer core: Moore control FSM, one shared ALU, one unified memory port.
// Latency at zero wait: lw 5, sw 4, R/addi 4, beq/j 3 cycles; each memory wait cycle adds 1.
// Backpressure: memory states hold req/addr/we/wdata stable and stall while mem_ready=0.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   mem_req/mem_we   transfer request and direction (1 = write)
//   mem_addr         word-aligned byte address, mem_wdata store data
//   mem_rdata        read data, sampled on the accepting edge
//   mem_ready        transfer completes on an edge with mem_req=1 and mem_ready=1
//   Test_Value       low TEST_WIDTH bits of register TEST_REG
//   halted           1 while in the terminal HALT state
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          TEST_REG   = 16,
    parameter int          TEST_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [TEST_WIDTH-1:0] Test_Value,
    output logic                  halted
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] TREG = TEST_REG[4:0];

    state_t state, state_next;

    logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out;
    logic [31:0] regs [0:31];

    // Instruction fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext;
    logic        funct_ok;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};

    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                      (funct == FN_OR)  || (funct == FN_SLT);

    // Register file: two combinational read ports, $0 hard-wired to zero
    logic [31:0] rd_a, rd_b;
    assign rd_a = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rd_b = (rt == 5'd0) ? 32'd0 : regs[rt];

    logic        xfer;
    assign xfer = mem_req && mem_ready;

    // Shared ALU: PC+4 in FETCH, branch target in DECODE, compare in BRANCH
    logic [31:0] alu_a, alu_b, alu_y;
    alu_ctl_t    alu_ctl;
    logic        alu_zero;

    always_comb begin
        alu_a   = pc;
        alu_b   = 32'd4;
        alu_ctl = ALU_ADD;
        case (state)
            DECODE: begin
                alu_a = pc;
                alu_b = {sext[29:0], 2'b00};
            end
            MEMADR, ADDIEX: begin
                alu_a = a_reg;
                alu_b = sext;
            end
            EXEC: begin
                alu_a = a_reg;
                alu_b = b_reg;
                case (funct)
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            BRANCH: begin
                alu_a   = a_reg;
                alu_b   = b_reg;
                alu_ctl = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = 32'd0;
        case (alu_ctl)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = 32'd0;
        endcase
    end

    assign alu_zero = (alu_y == 32'd0);

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (xfer) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = funct_ok ? EXEC : HALT;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default:      state_next = HALT;
                endcase
            end
            MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (xfer) state_next = MEMWB;
            MEMWB:  state_next = FETCH;
            MEMWR:  if (xfer) state_next = FETCH;
            EXEC:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            ADDIEX: state_next = ADDIWB;
            ADDIWB: state_next = FETCH;
            BRANCH: state_next = FETCH;
            JUMP:   state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Memory port: a function of state and rst only, never of mem_ready
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = 32'd0;
        if (!rst) begin
            mem_addr = RESET_PC;
        end else begin
            case (state)
                FETCH: mem_req = 1'b1;
                MEMRD: begin
                    mem_req  = 1'b1;
                    mem_addr = alu_out;
                end
                MEMWR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = alu_out;
                    mem_wdata = b_reg;
                end
                default: ;
            endcase
        end
    end

    // Register-file write port control
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        case (state)
            MEMWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr;
            end
            ALUWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                rf_wdata = alu_out;
            end
            ADDIWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = alu_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
        end else begin
            case (state)
                FETCH: if (xfer) begin
                    ir <= mem_rdata;
                    pc <= alu_y;
                end
                DECODE: begin
                    a_reg   <= rd_a;
                    b_reg   <= rd_b;
                    alu_out <= alu_y;
                end
                MEMADR, ADDIEX, EXEC: alu_out <= alu_y;
                MEMRD:  if (xfer) mdr <= mem_rdata;
                // alu_out still holds the target computed in DECODE
                BRANCH: if (alu_zero) pc <= alu_out;
                // pc already points past the jump, so its top nibble is the PC+4 region
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign Test_Value = (TREG == 5'd0) ? '0 : regs[TREG][TEST_WIDTH-1:0];
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a wait-state memory model.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] Test_Value;

    mips_multicycle_core #(
        .RESET_PC  (32'h0000_0000),
        .TEST_REG  (16),
        .TEST_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .Test_Value(Test_Value),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    localparam logic [5:0]  OP_ADDI = 6'h08;
    localparam logic [5:0]  OP_LW   = 6'h23;
    localparam logic [5:0]  OP_SW   = 6'h2B;
    localparam logic [5:0]  OP_BEQ  = 6'h04;
    localparam logic [31:0] ILL     = 32'hFC00_0000;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    // ---------------- memory model ----------------
    logic [31:0] mem  [0:127];
    logic [31:0] prog [0:127];
    int          waits = 0;
    int          cnt;
    int          load_req = 0;
    int          load_ack = 0;
    int          n_writes;
    logic [31:0] last_waddr, last_wdata;
    logic [31:0] rd_log [$];

    assign mem_ready = (cnt >= waits);
    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst)                       cnt <= 0;
        else if (mem_req && mem_ready)  cnt <= 0;
        else if (mem_req)               cnt <= cnt + 1;
    end

    always @(posedge clk) begin
        if (load_req != load_ack) begin
            for (int i = 0; i < 128; i++) mem[i] = prog[i];
            rd_log.delete();
            n_writes   = 0;
            last_waddr = 32'd0;
            last_wdata = 32'd0;
            load_ack   = load_req;
        end else if (rst && mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[8:2]] = mem_wdata;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
                n_writes++;
            end else begin
                rd_log.push_back(mem_addr);
            end
        end
    end

    // Request fields must hold steady until accepted
    logic        pend = 1'b0;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;

    always @(negedge clk) begin
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("hold_req",   {31'd0, mem_req}, 32'd1);
                check("hold_addr",  mem_addr, s_addr);
                check("hold_we",    {31'd0, mem_we}, {31'd0, s_we});
                check("hold_wdata", mem_wdata, s_wdata);
            end
            pend    = mem_req && !mem_ready;
            s_addr  = mem_addr;
            s_we    = mem_we;
            s_wdata = mem_wdata;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = 32'd0;
    endtask

    task automatic start(input int w);
        rst   = 1'b0;
        waits = w;
        load_req++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_halt(input int maxc, output int cyc);
        cyc = 0;
        while (!halted && cyc < maxc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    typedef struct {
        logic [15:0] ia;
        logic [15:0] ib;
        logic [5:0]  fn;
        int          w;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int cyc;
        int bad;
        logic [31:0] exp_reads [8];

        vt[0] = '{16'h0005, 16'h0007, 6'h20, 0, 16'h000C};
        vt[1] = '{16'h0005, 16'h0007, 6'h22, 1, 16'hFFFE};
        vt[2] = '{16'h0F0F, 16'h00FF, 6'h24, 0, 16'h000F};
        vt[3] = '{16'h0F00, 16'h00F0, 6'h25, 2, 16'h0FF0};
        vt[4] = '{16'hFFFF, 16'h0001, 6'h2A, 0, 16'h0001};
        vt[5] = '{16'h0001, 16'hFFFF, 6'h2A, 0, 16'h0000};
        vt[6] = '{16'h0003, 16'h0003, 6'h2A, 1, 16'h0000};
        vt[7] = '{16'h7FFF, 16'h7FFF, 6'h20, 0, 16'hFFFE};

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_req",   {31'd0, mem_req}, 32'd0);
        check("rst_we",    {31'd0, mem_we}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_tv",    {16'd0, Test_Value}, 32'd0);
        check("rst_halt",  {31'd0, halted}, 32'd0);

        // ALU vectors: preset $16, load operands, R-op into $16, halt
        for (int k = 0; k < 8; k++) begin
            clear_prog();
            prog[0] = ei(OP_ADDI, 5'd0, 5'd16, 16'h5A5A);
            prog[1] = ei(OP_ADDI, 5'd0, 5'd8, vt[k].ia);
            prog[2] = ei(OP_ADDI, 5'd0, 5'd9, vt[k].ib);
            prog[3] = er(5'd8, 5'd9, 5'd16, vt[k].fn);
            prog[4] = ILL;
            start(vt[k].w);
            run_halt(400, cyc);
            check($sformatf("vec%0d_tv", k), {16'd0, Test_Value}, {16'd0, vt[k].exp});
            check($sformatf("vec%0d_halt", k), {31'd0, halted}, 32'd1);
            check($sformatf("vec%0d_cycles", k), cyc, 18 + 5 * vt[k].w);
        end

        // Store then load with 3 wait states per request
        clear_prog();
        prog[0] = ei(OP_ADDI, 5'd0, 5'd17, 16'h000C);
        prog[1] = ei(OP_SW,   5'd0, 5'd17, 16'h0080);
        prog[2] = ei(OP_LW,   5'd0, 5'd16, 16'h0080);
        prog[3] = ILL;
        start(3);
        run_halt(400, cyc);
        check("ls_cycles", cyc, 33);
        check("ls_tv", {16'd0, Test_Value}, 32'h0000_000C);
        check("ls_nwrites", n_writes, 1);
        check("ls_waddr", last_waddr, 32'h0000_0080);
        check("ls_wdata", last_wdata, 32'h0000_000C);
        check("ls_mem", mem[32], 32'h0000_000C);

        // Branch not taken, branch taken, jump
        clear_prog();
        prog[0]  = ei(OP_ADDI, 5'd0, 5'd16, 16'h0001);
        prog[1]  = ei(OP_ADDI, 5'd0, 5'd17, 16'h0002);
        prog[2]  = ei(OP_ADDI, 5'd0, 5'd18, 16'h0002);
        prog[3]  = ei(OP_BEQ,  5'd16, 5'd17, 16'h0005);
        prog[4]  = ei(OP_BEQ,  5'd17, 5'd18, 16'h0002);
        prog[5]  = ILL;
        prog[6]  = ILL;
        prog[7]  = ej(26'h40);
        prog[64] = ei(OP_ADDI, 5'd0, 5'd16, 16'h0055);
        prog[65] = ILL;
        exp_reads = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h100, 32'h104};
        start(0);
        run_halt(400, cyc);
        check("bj_cycles", cyc, 27);
        check("bj_tv", {16'd0, Test_Value}, 32'h0000_0055);
        check("bj_nreads", rd_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_log.size())
                check($sformatf("bj_fetch%0d", i), rd_log[i], exp_reads[i]);
            else
                check($sformatf("bj_fetch%0d", i), 32'hDEAD_DEAD, exp_reads[i]);
        end

        // Writes to $0 are discarded; unlisted R funct halts
        clear_prog();
        prog[0] = ei(OP_ADDI, 5'd0, 5'd16, 16'h0009);
        prog[1] = er(5'd16, 5'd16, 5'd0, 6'h20);
        prog[2] = er(5'd0, 5'd0, 5'd16, 6'h20);
        prog[3] = er(5'd16, 5'd16, 5'd16, 6'h26);
        start(0);
        run_halt(400, cyc);
        check("r0_tv", {16'd0, Test_Value}, 32'd0);
        check("r0_cycles", cyc, 14);

        // Illegal opcode halts two cycles after its fetch, then stays quiet
        clear_prog();
        prog[0] = ei(OP_ADDI, 5'd0, 5'd16, 16'h0033);
        prog[1] = ILL;
        start(0);
        run_halt(400, cyc);
        check("ill_cycles", cyc, 6);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        check("ill_quiet", bad, 0);
        check("ill_tv", {16'd0, Test_Value}, 32'h0000_0033);

        // Asynchronous reset in the middle of a load stall
        clear_prog();
        prog[0]  = ei(OP_ADDI, 5'd0, 5'd16, 16'h0077);
        prog[1]  = ei(OP_LW,   5'd0, 5'd16, 16'h0080);
        prog[2]  = ILL;
        prog[32] = 32'h0000_1234;
        start(4);
        cyc = 0;
        while (!(mem_req && mem_addr == 32'h80) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("ar_reached_memrd", {31'd0, (mem_req && mem_addr == 32'h80)}, 32'd1);
        check("ar_tv_before", {16'd0, Test_Value}, 32'h0000_0077);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_req", {31'd0, mem_req}, 32'd0);
        check("ar_we", {31'd0, mem_we}, 32'd0);
        check("ar_addr", mem_addr, 32'd0);
        check("ar_tv", {16'd0, Test_Value}, 32'd0);
        check("ar_halt", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ar_first_req", {31'd0, mem_req}, 32'd1);
        check("ar_first_addr", mem_addr, 32'd0);
        check("ar_first_we", {31'd0, mem_we}, 32'd0);
        check("ar_first_tv", {16'd0, Test_Value}, 32'd0);
        run_halt(400, cyc);
        check("ar_rerun_cycles", cyc, 27);
        check("ar_rerun_tv", {16'd0, Test_Value}, 32'h0000_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
